// File: rtl/input_loader_pkg.sv
// rtl/input_loader_pkg.sv - shared types and helpers for the input feature-map loader
//
// Contents:
//   state_t        : loader FSM states (IDLE, LOAD, DONE)
//   rows_per_bank  : ceil(height / bank_num), the number of rows one bank receives
package input_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide arguments so the depth product in the error check cannot overflow.
    function automatic logic [63:0] rows_per_bank(input logic [63:0] height,
                                                  input logic [63:0] bank_num);
        return (height + bank_num - 64'd1) / bank_num;
    endfunction

endpackage

// File: rtl/input_loader_if.sv
// rtl/input_loader_if.sv - command, pixel stream and BRAM write bus of the input loader
//
// Signals:
//   i_start, i_img_width, i_img_height : start command and image dimensions
//   i_valid, i_data, o_ready           : pixel word stream
//   o_enable, o_wenable, o_waddress    : per-bank port-A controls
//   o_bram_data                        : shared write data
//   o_busy, o_done, o_error            : status
// Modports: slave = loader side, master = host/memory side.
interface input_loader_if #(
    parameter int INPUT_BRAM_NUM           = 4,
    parameter int INPUT_BRAM_ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH               = 32
);
    logic                                i_start;
    logic [INPUT_BRAM_ADDRESS_WIDTH-1:0] i_img_width;
    logic [INPUT_BRAM_ADDRESS_WIDTH-1:0] i_img_height;
    logic                                i_valid;
    logic [DATA_WIDTH-1:0]               i_data;
    logic                                o_ready;
    logic [0:0]                          o_enable   [0:INPUT_BRAM_NUM-1];
    logic [0:0]                          o_wenable  [0:INPUT_BRAM_NUM-1];
    logic [INPUT_BRAM_ADDRESS_WIDTH-1:0] o_waddress [0:INPUT_BRAM_NUM-1];
    logic [DATA_WIDTH-1:0]               o_bram_data;
    logic                                o_busy;
    logic                                o_done;
    logic                                o_error;

    modport slave (
        input  i_start, i_img_width, i_img_height, i_valid, i_data,
        output o_ready, o_enable, o_wenable, o_waddress, o_bram_data,
               o_busy, o_done, o_error
    );

    modport master (
        output i_start, i_img_width, i_img_height, i_valid, i_data,
        input  o_ready, o_enable, o_wenable, o_waddress, o_bram_data,
               o_busy, o_done, o_error
    );
endinterface

// File: rtl/input_loader_addr_gen.sv
// rtl/input_loader_addr_gen.sv - column/row/bank/base counters for round-robin row placement
//
// Ports:
//   i_clock, i_reset     : clock, synchronous active-high reset
//   i_clear              : restart counters at the first pixel of a new image
//   i_advance            : one pixel accepted, step to the next position
//   i_width, i_height    : latched image dimensions
//   o_bank, o_address    : target bank and in-bank address of the current pixel
//   o_last               : current pixel is the final pixel of the image
module input_loader_addr_gen #(
    parameter int INPUT_BRAM_NUM           = 4,
    parameter int INPUT_BRAM_ADDRESS_WIDTH = 16,
    parameter int BANK_WIDTH               = 2
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    input  logic                                i_clear,
    input  logic                                i_advance,
    input  logic [INPUT_BRAM_ADDRESS_WIDTH-1:0] i_width,
    input  logic [INPUT_BRAM_ADDRESS_WIDTH-1:0] i_height,
    output logic [BANK_WIDTH-1:0]               o_bank,
    output logic [INPUT_BRAM_ADDRESS_WIDTH-1:0] o_address,
    output logic                                o_last
);
    localparam int AW = INPUT_BRAM_ADDRESS_WIDTH;
    localparam logic [BANK_WIDTH-1:0] BANK_LAST = BANK_WIDTH'(INPUT_BRAM_NUM - 1);

    logic [AW-1:0]         r_col;
    logic [AW-1:0]         r_row;
    logic [BANK_WIDTH-1:0] r_bank;
    logic [AW-1:0]         r_base;
    logic                  w_col_end;
    logic                  w_row_end;

    // A zero dimension minus one wraps to all ones, so zero behaves as 2^AW.
    assign w_col_end = (r_col == i_width - AW'(1));
    assign w_row_end = (r_row == i_height - AW'(1));

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_col  <= '0;
            r_row  <= '0;
            r_bank <= '0;
            r_base <= '0;
        end else if (i_advance) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + AW'(1);
                // Every bank has received one more row: move all banks down by a row.
                if (r_bank == BANK_LAST) begin
                    r_bank <= '0;
                    r_base <= r_base + i_width;
                end else begin
                    r_bank <= r_bank + BANK_WIDTH'(1);
                end
            end else begin
                r_col <= r_col + AW'(1);
            end
        end
    end

    assign o_bank    = r_bank;
    assign o_address = r_base + r_col;
    assign o_last    = w_col_end && w_row_end;

endmodule

// File: rtl/input_loader.sv
// rtl/input_loader.sv - write-side sequencer spreading image rows across the input BRAM banks
//
// Ports:
//   i_clock : single clock
//   i_reset : synchronous active-high reset
//   bus     : input_loader_if.slave (start command, pixel stream, BRAM write bus, status)
// Optional feature: define INPUT_LOADER_ERR_CHECK_EN to reject zero-sized or
// oversized start commands and report them on the sticky o_error flag.
module input_loader
    import input_loader_pkg::*;
#(
    parameter int INPUT_BRAM_NUM           = 4,
    parameter int INPUT_BRAM_ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH               = 32
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input_loader_if.slave   bus
);
    localparam int AW = INPUT_BRAM_ADDRESS_WIDTH;
    localparam int BW = (INPUT_BRAM_NUM > 1) ? $clog2(INPUT_BRAM_NUM) : 1;

    state_t                r_state;
    state_t                w_next_state;
    logic [AW-1:0]         r_width;
    logic [AW-1:0]         r_height;
    logic                  w_cfg_ok;
    logic                  w_start_ok;
    logic                  w_accept;
    logic [BW-1:0]         w_bank;
    logic [AW-1:0]         w_address;
    logic                  w_last;
    logic                  r_enable [0:INPUT_BRAM_NUM-1];
    logic [AW-1:0]         r_waddress;
    logic [DATA_WIDTH-1:0] r_data;

`ifdef INPUT_LOADER_ERR_CHECK_EN
    logic [63:0] w_depth;
    logic        r_error;

    assign w_depth  = 64'(bus.i_img_width)
                    * rows_per_bank(64'(bus.i_img_height), 64'(INPUT_BRAM_NUM));
    assign w_cfg_ok = (bus.i_img_width != '0) && (bus.i_img_height != '0)
                   && (w_depth <= (64'd1 << AW));

    // Sticky until reset or until a start command is actually taken.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_error <= 1'b0;
        end else if (r_state == IDLE && bus.i_start) begin
            r_error <= !w_cfg_ok;
        end
    end

    assign bus.o_error = r_error;
`else
    assign w_cfg_ok    = 1'b1;
    assign bus.o_error = 1'b0;
`endif

    assign w_start_ok = (r_state == IDLE) && bus.i_start && w_cfg_ok;
    assign w_accept   = (r_state == LOAD) && bus.i_valid;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_next_state = LOAD;
            LOAD:    if (w_accept && w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_width  <= '0;
            r_height <= '0;
        end else if (w_start_ok) begin
            r_width  <= bus.i_img_width;
            r_height <= bus.i_img_height;
        end
    end

    input_loader_addr_gen #(
        .INPUT_BRAM_NUM           (INPUT_BRAM_NUM),
        .INPUT_BRAM_ADDRESS_WIDTH (AW),
        .BANK_WIDTH               (BW)
    ) u_addr_gen (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (w_start_ok),
        .i_advance (w_accept),
        .i_width   (r_width),
        .i_height  (r_height),
        .o_bank    (w_bank),
        .o_address (w_address),
        .o_last    (w_last)
    );

    // Strobes last exactly one cycle; address and data hold between writes.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_waddress <= '0;
            r_data     <= '0;
            for (int b = 0; b < INPUT_BRAM_NUM; b++) begin
                r_enable[b] <= 1'b0;
            end
        end else begin
            for (int b = 0; b < INPUT_BRAM_NUM; b++) begin
                r_enable[b] <= w_accept && (w_bank == BW'(b));
            end
            if (w_accept) begin
                r_waddress <= w_address;
                r_data     <= bus.i_data;
            end
        end
    end

    for (genvar g = 0; g < INPUT_BRAM_NUM; g++) begin : g_bank
        assign bus.o_enable[g]   = r_enable[g];
        assign bus.o_wenable[g]  = r_enable[g];
        assign bus.o_waddress[g] = r_waddress;
    end

    assign bus.o_bram_data = r_data;
    assign bus.o_ready     = (r_state == LOAD);
    assign bus.o_busy      = (r_state != IDLE);
    assign bus.o_done      = (r_state == DONE);

endmodule
